uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_bit_timer.sv | 35 +++
 rtl/uart_rx_framer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default baud divisor.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_BAUD_DEFAULT = 5207;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter for the UART receiver: counts 0..BAUD while running and
// flags the mid-bit sample point and the end-of-bit wrap.
module uart_rx_bit_timer
    import uart_pkg::*;
#(
    parameter int BAUD = UART_BAUD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sample,
    output logic wrap
);

    localparam int                CNT_W   = (BAUD > 0) ? $clog2(BAUD + 1) : 1;
    localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(BAUD);
    localparam logic [CNT_W-1:0]  LP_HALF = CNT_W'(BAUD / 2);

    logic [CNT_W-1:0] r_count;

    // Held at zero while idle so a new frame always starts timing from the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!run || r_count == LP_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign sample = run && (r_count == LP_HALF);
    assign wrap   = run && (r_count == LP_LAST);

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver with valid/ready output, mid-bit sampling, glitch rejection
// on the start bit, and frame-error / overrun pulses.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int BAUD = UART_BAUD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   rx_busy,
    output logic                   frame_err,
    output logic                   overrun
);

    logic                   r_rxMeta;
    logic                   r_rxSync;
    logic                   r_rxPrev;
    rx_state_t              r_state;
    rx_state_t              w_nextState;
    logic [2:0]             r_bitIdx;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_rxData;
    logic                   r_rxValid;
    logic                   r_frameErr;
    logic                   r_overrun;
    logic                   w_run;
    logic                   w_sample;
    logic                   w_wrap;
    logic                   w_goodByte;
    logic                   w_badStop;

    // Synchronizer and edge-history flops reset to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
        end
    end

    assign w_run = (r_state != ST_IDLE);

    uart_rx_bit_timer #(
        .BAUD   (BAUD)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (w_run),
        .sample (w_sample),
        .wrap   (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The stop bit is judged at its midpoint and the FSM leaves immediately,
    // giving half a bit of slack to catch the next start edge.
    always_comb begin
        w_nextState = r_state;
        w_goodByte  = 1'b0;
        w_badStop   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rxPrev && !r_rxSync) w_nextState = ST_START;
            end
            ST_START: begin
                if (w_sample && r_rxSync) w_nextState = ST_IDLE;
                else if (w_wrap)          w_nextState = ST_DATA;
            end
            ST_DATA: begin
                if (w_wrap && r_bitIdx == 3'd7) w_nextState = ST_STOP;
            end
            ST_STOP: begin
                if (w_sample) begin
                    w_nextState = ST_IDLE;
                    w_goodByte  = r_rxSync;
                    w_badStop   = !r_rxSync;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitIdx <= 3'd0;
            r_shift  <= '0;
        end else begin
            if (r_state == ST_START && w_wrap) r_bitIdx <= 3'd0;
            if (r_state == ST_DATA && w_sample) r_shift[r_bitIdx] <= r_rxSync;
            if (r_state == ST_DATA && w_wrap) r_bitIdx <= r_bitIdx + 3'd1;
        end
    end

    // A held byte is never overwritten; a new byte only lands if the old one
    // is absent or being consumed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxData   <= '0;
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_frameErr <= w_badStop;
            r_overrun  <= 1'b0;
            if (w_goodByte) begin
                if (!r_rxValid || rx_ready) begin
                    r_rxData  <= r_shift;
                    r_rxValid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rxValid && rx_ready) begin
                r_rxValid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rxData;
    assign rx_valid  = r_rxValid;
    assign rx_busy   = w_run;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;

endmodule
